// File: rtl/req_initiator.sv
// Bus-request initiator: FIFO-buffered write commands issued over the addr/data/rdy/ack handshake.
// Optional WAIT timeout compiled in with `define REQ_INITIATOR_TMO_EN.
module req_initiator #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              rdy,
  input  logic              ack,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] mem_addr_r [DEPTH];
  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic              done_s;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              done_r;
  logic              busy_r;

`ifdef REQ_INITIATOR_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] tmo_cnt_r;
  logic       fail_s;
  logic       err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Full is judged on the registered count only, so a same-edge pop never frees a slot early.
  assign cmd_rdy = (count_r != CNT_W'(DEPTH));
  assign push_s  = cmd_vld & cmd_rdy;
  assign req     = req_r;
  assign addr    = addr_r;
  assign data    = data_r;
  assign done    = done_r;
  assign busy    = busy_r;

  // Completion decode: the head entry leaves the FIFO only when its command finishes.
  always_comb begin
    done_s = 1'b0;
`ifdef REQ_INITIATOR_TMO_EN
    fail_s = 1'b0;
`endif
    case (state_r)
      REQ: begin
        if (rdy && ack) done_s = 1'b1;
        else            done_s = 1'b0;
      end
      WAIT: begin
        if (ack) done_s = 1'b1;
`ifdef REQ_INITIATOR_TMO_EN
        else if (tmo_cnt_r == TMO_LAST) fail_s = 1'b1;
`endif
        else done_s = 1'b0;
      end
      default: done_s = 1'b0;
    endcase
`ifdef REQ_INITIATOR_TMO_EN
    pop_s = done_s | fail_s;
`else
    pop_s = done_s;
`endif
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Command storage; contents need no reset since count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= cmd_addr;
      mem_data_r[wr_ptr_r] <= cmd_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nxt_s;
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      req_r     <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef REQ_INITIATOR_TMO_EN
      err_r     <= 1'b0;
      tmo_cnt_r <= 8'd0;
`endif
    end else begin
      done_r <= done_s;
      // The FSM is only active while its head is still queued, so occupancy alone covers busy.
      busy_r <= (count_nxt_s != CNT_W'(0));
`ifdef REQ_INITIATOR_TMO_EN
      err_r  <= fail_s;
`endif
      case (state_r)
        IDLE: begin
          if (count_r != CNT_W'(0)) begin
            addr_r  <= mem_addr_r[rd_ptr_r];
            data_r  <= mem_data_r[rd_ptr_r];
            req_r   <= 1'b1;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (rdy) begin
            req_r   <= 1'b0;
            state_r <= ack ? IDLE : WAIT;
`ifdef REQ_INITIATOR_TMO_EN
            tmo_cnt_r <= 8'd0;
`endif
          end
        end
        WAIT: begin
          if (pop_s) state_r <= IDLE;
`ifdef REQ_INITIATOR_TMO_EN
          else tmo_cnt_r <= tmo_cnt_r + 8'd1;
`endif
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
